// File: rtl/instr_mem.sv
// Fixed 64-word instruction ROM for the single-cycle core.
// Combinational fetch; reset forces a NOP onto the output.
module instr_mem (
    input  logic        sysclk,
    input  logic [7:0]  curr_pc,
    output logic [31:0] instruction,
    input  logic        reset
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [5:0]  word_idx;
    logic [31:0] rom_word;
    logic        unused_ok;

    // Byte offset within a word is dropped; misaligned PCs hit the
    // containing word. The clock only exists for port compatibility.
    assign word_idx  = curr_pc[7:2];
    assign unused_ok = ^{sysclk, curr_pc[1:0]};

    always_comb begin
        rom_word = NOP;
        unique case (word_idx)
            6'd0:    rom_word = 32'h0050_0093;
            6'd1:    rom_word = 32'h00A0_0113;
            6'd2:    rom_word = 32'h0020_81B3;
            6'd3:    rom_word = 32'h4011_0233;
            6'd4:    rom_word = 32'h0020_F2B3;
            6'd5:    rom_word = 32'h0020_E333;
            6'd6:    rom_word = 32'h0030_2023;
            6'd7:    rom_word = 32'h0000_2383;
            6'd8:    rom_word = 32'h0071_8463;
            6'd9:    rom_word = 32'h0010_0413;
            6'd10:   rom_word = 32'h0020_0493;
            6'd11:   rom_word = 32'h0000_006F;
            default: rom_word = NOP;
        endcase
    end

    assign instruction = reset ? NOP : rom_word;

endmodule

// File: tb/tb_instr_mem.sv
// Randomised bench for instr_mem against a program-table model.
// Directed boundary cases first, then random PC/reset traffic.
module tb_instr_mem;

    logic        sysclk;
    logic        reset;
    logic [7:0]  curr_pc;
    logic [31:0] instruction;
    logic        clk_en;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [31:0] PROG [0:11] = '{
        32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3,
        32'h4011_0233, 32'h0020_F2B3, 32'h0020_E333,
        32'h0030_2023, 32'h0000_2383, 32'h0071_8463,
        32'h0010_0413, 32'h0020_0493, 32'h0000_006F
    };

    instr_mem dut (
        .sysclk      (sysclk),
        .curr_pc     (curr_pc),
        .instruction (instruction),
        .reset       (reset)
    );

    always #5 if (clk_en) sysclk = ~sysclk;

    function automatic logic [31:0] model(
        input logic       rst,
        input logic [7:0] pc
    );
        int idx;
        idx = int'(pc) / 4;
        if (rst) return NOP;
        if (idx < 12) return PROG[idx];
        return NOP;
    endfunction

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] pc, input string tag);
        curr_pc = pc;
        #5;
        check(tag, instruction, model(reset, pc));
    endtask

    initial begin
        clk_en  = 1'b0;
        sysclk  = 1'b1;
        reset   = 1'b1;
        curr_pc = 8'h00;
        #1;
        check("reset_state", instruction, NOP);

        reset = 1'b0;
        #5;
        check("pc00", instruction, 32'h0050_0093);
        curr_pc = 8'h04;
        #5;
        check("pc04", instruction, 32'h00A0_0113);
        curr_pc = 8'h40;
        #5;
        check("pc40", instruction, NOP);

        for (int a = 0; a <= 8'h2C; a += 4)
            fetch(8'(a), "sweep");
        curr_pc = 8'h2C;
        #5;
        check("halt", instruction, 32'h0000_006F);

        fetch(8'h30, "first_nop");
        fetch(8'hFC, "last_word");
        fetch(8'hFF, "pc_ff");
        curr_pc = 8'h09;
        #5;
        check("mis09", instruction, 32'h0020_81B3);
        curr_pc = 8'h0A;
        #5;
        check("mis0a", instruction, 32'h0020_81B3);
        curr_pc = 8'h0B;
        #5;
        check("mis0b", instruction, 32'h0020_81B3);

        curr_pc = 8'h08;
        #2;
        reset = 1'b1;
        #0;
        #1;
        check("rst_assert", instruction, NOP);
        reset = 1'b0;
        #1;
        check("rst_release", instruction, 32'h0020_81B3);

        reset = 1'b1;
        curr_pc = 8'h00;
        #5;
        check("rst_pc00", instruction, NOP);
        curr_pc = 8'h14;
        #5;
        check("rst_pc14", instruction, NOP);
        curr_pc = 8'h2C;
        #5;
        check("rst_pc2c", instruction, NOP);
        reset = 1'b0;
        #1;
        check("rst_exit2c", instruction, 32'h0000_006F);

        clk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] pc;
            if ($urandom_range(1))
                pc = 8'($urandom_range(47));
            else
                pc = 8'($urandom);
            reset   = ($urandom_range(7) == 0);
            curr_pc = pc;
            #3;
            check("rand", instruction, model(reset, pc));
        end
        clk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
